// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART <-> ALU glue: FSM state encoding and ALU opcodes.
// The opcode constants are shared by the ALU and by anything that models it.
package uart_alu_pkg;

    localparam int NB_STATE = 3;

    typedef enum logic [NB_STATE-1:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/interbyte_timer.sv
// Idle-gap counter between bytes of one frame; flags the last allowed idle cycle.
// Held at zero while disabled, restarted by clear.
module interbyte_timer #(
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] count;

    // A clear on the final cycle means a byte arrived in time, so no expiry.
    assign expired = enable && !clear && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + NB_TIMEOUT'(1);
        end
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Assembles A, B, opcode from received bytes, presents them to the ALU and
// hands the registered result to the UART transmitter as a single byte.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OPCODE      = 6,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int NB_TIMEOUT     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx_data_valid,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_data_a,
    output logic [NB_DATA-1:0]   o_data_b,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic [NB_STATE-1:0]  o_state
);

    // Handshake: i_rx_data_valid and i_tx_done are single-cycle pulses with no
    // back-pressure; o_tx_start is a single-cycle request and o_tx_data stays
    // stable until the matching i_tx_done. Bytes arriving while busy are dropped.

    state_t state, state_next;
    logic   load_a, load_b, load_op, load_tx, timeout_next;
    logic   timer_enable, timer_expired;

    assign timer_enable = (state == WAIT_B) || (state == WAIT_OP);
    assign o_busy       = (state == EXEC) || (state == SEND);
    assign o_state      = state;

    interbyte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .NB_TIMEOUT    (NB_TIMEOUT)
    ) u_timer (
        .clk    (i_clock),
        .rst_n  (i_reset),
        .clear  (i_rx_data_valid),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_next   = state;
        load_a       = 1'b0;
        load_b       = 1'b0;
        load_op      = 1'b0;
        load_tx      = 1'b0;
        timeout_next = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_data_valid) begin
                    load_a     = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_data_valid) begin
                    load_b     = 1'b1;
                    state_next = WAIT_OP;
                end else if (timer_expired) begin
                    timeout_next = 1'b1;
                    state_next   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_data_valid) begin
                    load_op    = 1'b1;
                    state_next = EXEC;
                end else if (timer_expired) begin
                    timeout_next = 1'b1;
                    state_next   = WAIT_A;
                end
            end
            EXEC: begin
                load_tx    = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: state_next = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= WAIT_A;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_opcode   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_next;
            o_tx_start <= load_tx;
            o_timeout  <= timeout_next;
            if (load_a)  o_data_a  <= i_rx_data;
            if (load_b)  o_data_b  <= i_rx_data;
            if (load_op) o_opcode  <= i_rx_data[NB_OPCODE-1:0];
            if (load_tx) o_tx_data <= i_alu_result;
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scenario bench for uart_alu_interface with a behavioural ALU and an
// expected-result queue checked against each transmit request.
module tb_uart_alu_interface;
    import uart_alu_pkg::*;

    localparam int TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] data_a, data_b, tx_data;
    logic [5:0] opcode;
    logic       tx_start, busy, timeout;
    logic [2:0] state;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         timeout_pulses = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    uart_alu_interface #(
        .NB_DATA(8), .NB_OPCODE(6), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_rx_data_valid(rx_valid),
        .i_rx_data      (rx_data),
        .i_tx_done      (tx_done),
        .i_alu_result   (alu_result),
        .o_data_a       (data_a),
        .o_data_b       (data_b),
        .o_opcode       (opcode),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_busy         (busy),
        .o_timeout      (timeout),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return $signed(a) >>> b;
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(data_a, data_b, opcode);

    always @(negedge clk) if (timeout) timeout_pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic wait_tx_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input logic [7:0] expv);
        bit seen;
        exp_q.push_back(expv);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
        wait_tx_start(seen);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL frame_tx_start: no o_tx_start within 20 cycles (expected byte %h)", exp_v);
        end else if (tx_data !== exp_v) begin
            n_fail++;
            $display("FAIL frame_tx_data: got %h expected %h", tx_data, exp_v);
        end
        pulse_tx_done();
        n_checks++;
        if (busy !== 1'b0 || state !== WAIT_A) begin
            n_fail++;
            $display("FAIL frame_idle: busy=%b state=%0d expected busy=0 state=0", busy, state);
        end
    endtask

    task automatic test_reset();
        int starts;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_a !== 8'h00 || data_b !== 8'h00 || opcode !== 6'h00 || tx_data !== 8'h00 ||
            tx_start !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 || state !== WAIT_A) begin
            n_fail++;
            $display("FAIL reset_clear: a=%h b=%h op=%h tx=%h start=%b busy=%b to=%b st=%0d expected all 0",
                     data_a, data_b, opcode, tx_data, tx_start, busy, timeout, state);
        end
        send_byte(8'h56);
        send_byte(8'h78);
        @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        n_checks++;
        if (starts !== 0 || state !== WAIT_A || data_a !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_quiet: tx_starts=%0d state=%0d a=%h expected 0/0/00", starts, state, data_a);
        end
    endtask

    task automatic test_basic();
        exp_q.push_back(8'h08);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        n_checks++;
        if (state !== EXEC || busy !== 1'b1 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_exec: state=%0d busy=%b start=%b expected 3/1/0", state, busy, tx_start);
        end
        n_checks++;
        if (data_a !== 8'h05 || data_b !== 8'h03 || opcode !== 6'h20) begin
            n_fail++;
            $display("FAIL basic_operands: a=%h b=%h op=%h expected 05/03/20", data_a, data_b, opcode);
        end
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== exp_v || state !== SEND) begin
            n_fail++;
            $display("FAIL basic_start: start=%b tx=%h state=%0d expected 1/%h/4", tx_start, tx_data, state, exp_v);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b0 || tx_data !== 8'h08 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold: start=%b tx=%h busy=%b expected 0/08/1", tx_start, tx_data, busy);
        end
        pulse_tx_done();
        n_checks++;
        if (busy !== 1'b0 || state !== WAIT_A) begin
            n_fail++;
            $display("FAIL basic_done: busy=%b state=%0d expected 0/0", busy, state);
        end
    endtask

    task automatic test_opcode_mask();
        do_frame(8'h03, 8'h05, 8'hE2, 8'hFE);
        n_checks++;
        if (opcode !== OP_SUB) begin
            n_fail++;
            $display("FAIL opcode_mask: got %h expected %h", opcode, OP_SUB);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'h11);
        repeat (TIMEOUT - 1) @(negedge clk);
        n_checks++;
        if (state !== WAIT_B || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: state=%0d to=%b expected 1/0", state, timeout);
        end
        @(negedge clk);
        n_checks++;
        if (state !== WAIT_A || timeout !== 1'b1 || data_a !== 8'h11) begin
            n_fail++;
            $display("FAIL timeout_fire: state=%0d to=%b a=%h expected 0/1/11", state, timeout, data_a);
        end
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse_width: to=%b expected 0", timeout);
        end
        do_frame(8'hAA, 8'h55, 8'h24, 8'h00);
    endtask

    task automatic test_expiry_boundary();
        int  p;
        bit  seen;
        p = timeout_pulses;
        exp_q.push_back(8'h30);
        send_byte(8'h10);
        repeat (TIMEOUT - 2) @(negedge clk);
        send_byte(8'h20);
        n_checks++;
        if (state !== WAIT_OP || timeout !== 1'b0 || data_b !== 8'h20) begin
            n_fail++;
            $display("FAIL boundary_b: state=%0d to=%b b=%h expected 2/0/20", state, timeout, data_b);
        end
        repeat (TIMEOUT - 2) @(negedge clk);
        send_byte(8'h20);
        n_checks++;
        if (state !== EXEC || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_op: state=%0d to=%b expected 3/0", state, timeout);
        end
        wait_tx_start(seen);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (!seen || tx_data !== exp_v) begin
            n_fail++;
            $display("FAIL boundary_tx: seen=%b tx=%h expected 1/%h", seen, tx_data, exp_v);
        end
        pulse_tx_done();
        @(negedge clk);
        n_checks++;
        if (timeout_pulses !== p) begin
            n_fail++;
            $display("FAIL boundary_no_timeout: pulses=%0d expected %0d", timeout_pulses, p);
        end
    endtask

    task automatic test_busy_drop();
        bit seen;
        int starts;
        exp_q.push_back(8'h10);
        send_byte(8'h40);
        send_byte(8'h02);
        send_byte({2'b11, OP_SRL});
        wait_tx_start(seen);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (!seen || tx_data !== exp_v) begin
            n_fail++;
            $display("FAIL drop_first_tx: seen=%b tx=%h expected 1/%h", seen, tx_data, exp_v);
        end
        send_byte(8'h77);
        n_checks++;
        if (state !== SEND || data_a !== 8'h40) begin
            n_fail++;
            $display("FAIL drop_in_send: state=%0d a=%h expected 4/40", state, data_a);
        end
        pulse_tx_done();
        pulse_tx_done();
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        n_checks++;
        if (state !== WAIT_A || starts !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_tx_done: state=%0d starts=%0d busy=%b expected 0/0/0", state, starts, busy);
        end
        do_frame(8'h01, 8'h01, 8'h20, 8'h02);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8];
        logic [7:0] a, b, opb;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
        for (int i = 0; i < 8; i++) begin
            a   = 8'($urandom_range(0, 255));
            b   = (i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
            do_frame(a, b, opb, alu_model(a, b, opb[5:0]));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_opcode_mask();
        test_timeout();
        test_expiry_boundary();
        test_busy_drop();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
